// File: rtl/rc_adder_pkg.sv
// Shared definitions for the rc_adder32 ripple-carry adder slice.
package rc_adder_pkg;

  localparam int RC_WIDTH_DEFAULT = 32;

  typedef logic [31:0] word_t;

endpackage : rc_adder_pkg

// File: rtl/full_adder.sv
// One-bit full-adder cell; replicated and chained to form the ripple carry path.
module full_adder
  import rc_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : full_adder

// File: rtl/rc_adder32.sv
// Registered ripple-carry adder: Sum/cOut = A + B + cIn with one cycle of latency.
// Define RC_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module rc_adder32
  import rc_adder_pkg::*;
#(
  parameter int WIDTH = RC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cIn,
  output logic [WIDTH-1:0] Sum,
  output logic             cOut,
  output logic             out_valid
`ifdef RC_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  logic [WIDTH-1:0] r_sum_p1;
  logic             r_cout_p1;
  logic             r_vld_p1;

  assign w_c[0] = cIn;

  // Stage 0: pure ripple chain, carry flows bit 0 -> bit WIDTH-1
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    full_adder u_fa (
      .a    (A[gi]),
      .b    (B[gi]),
      .cin  (w_c[gi]),
      .s    (w_s[gi]),
      .cout (w_c[gi+1])
    );
  end

  // Stage 1: output registers; data loads only on in_valid so idle inputs cannot disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_p1  <= '0;
      r_cout_p1 <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_sum_p1  <= w_s;
        r_cout_p1 <= w_c[WIDTH];
      end
    end
  end

  assign Sum       = r_sum_p1;
  assign cOut      = r_cout_p1;
  assign out_valid = r_vld_p1;

`ifdef RC_ADDER_OVF_EN
  logic r_ovf_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_p1 <= 1'b0;
    end else if (in_valid) begin
      r_ovf_p1 <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign ovf = r_ovf_p1;
`endif

endmodule : rc_adder32

// File: tb/tb_rc_adder32.sv
// Directed self-checking bench for rc_adder32 (covers ovf when RC_ADDER_OVF_EN is defined).
module tb_rc_adder32;
  import rc_adder_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  in_valid;
  word_t A;
  word_t B;
  logic  cIn;
  word_t Sum;
  logic  cOut;
  logic  out_valid;
`ifdef RC_ADDER_OVF_EN
  logic  ovf;
`endif

  int n_total;
  int n_bad;

  rc_adder32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .cIn       (cIn),
    .Sum       (Sum),
    .cOut      (cOut),
    .out_valid (out_valid)
`ifdef RC_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input word_t a, input word_t b, input logic ci);
    @(negedge clk);
    in_valid = v;
    A        = a;
    B        = b;
    cIn      = ci;
  endtask

  // Apply one valid operation and check the registered result one cycle later.
  task automatic op(input string tag, input word_t a, input word_t b, input logic ci,
                    input word_t exp_s, input logic exp_c, input logic exp_o);
    drive(1'b1, a, b, ci);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_sum"}, Sum, exp_s);
    check_eq({tag, "_cout"}, cOut, exp_c);
    check_eq({tag, "_vld"}, out_valid, 1'b1);
`ifdef RC_ADDER_OVF_EN
    check_eq({tag, "_ovf"}, ovf, exp_o);
`else
    if (exp_o === 1'bx) check_eq({tag, "_ovfx"}, exp_o, 1'b0);
`endif
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    cIn      = 1'b0;

    // Load a value, then assert reset between edges and check it clears immediately
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    drive(1'b1, 32'd7, 32'd8, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("pre_rst_sum", Sum, 32'd15);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_sum", Sum, 32'd0);
    check_eq("rst_cout", cOut, 1'b0);
    check_eq("rst_vld", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back operations followed by idle hold
    drive(1'b1, 32'd42, 32'd58, 1'b0);
    drive(1'b1, 32'd105, 32'd21, 1'b0);
    check_eq("b2b1_sum", Sum, 32'd100);
    check_eq("b2b1_cout", cOut, 1'b0);
    check_eq("b2b1_vld", out_valid, 1'b1);
    drive(1'b0, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b1);
    check_eq("b2b2_sum", Sum, 32'd126);
    check_eq("b2b2_cout", cOut, 1'b0);
    check_eq("b2b2_vld", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom, $urandom, 1'($urandom));
      check_eq($sformatf("hold%0d_sum", i), Sum, 32'd126);
      check_eq($sformatf("hold%0d_vld", i), out_valid, 1'b0);
    end

    op("wrap",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    op("sub",     32'd100,       ~32'd30,       1'b1, 32'd70,        1'b1, 1'b0);
    op("subneg",  32'd30,        ~32'd100,      1'b1, 32'hFFFF_FFBA, 1'b0, 1'b0);
    op("alt",     32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    op("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    op("negovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    op("noovf",   32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Reset during an in-flight operation discards it
    drive(1'b1, 32'd1, 32'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_sum", Sum, 32'd0);
    check_eq("midrst_vld", out_valid, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("postrst_sum", Sum, 32'd0);
    check_eq("postrst_vld", out_valid, 1'b0);
    op("resume", 32'd3, 32'd4, 1'b1, 32'd8, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_rc_adder32
